// File: rtl/ram_bus_pkg.sv
// Shared types and default widths for the RAM bus master.
// The FSM state encoding lives here so the bench and the RTL use one definition.
package ram_bus_pkg;

  localparam int RBM_ADDR_W = 5;
  localparam int RBM_DATA_W = 8;

  typedef enum logic [2:0] {INIT, IDLE, WR, RD_CMD, RD_CAP, RSP} rbm_state_t;

  typedef logic [RBM_ADDR_W-1:0] addr_t;
  typedef logic [RBM_DATA_W-1:0] data_t;

endpackage

// File: rtl/ram_bus_master.sv
// Host valid/ready request stream to single-port RAM tri-state bus cycles.
// Define RAM_BUS_MASTER_ASSERT_EN to compile in the bus protocol assertions.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = RBM_ADDR_W,
  parameter int DATA_W = RBM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_wd,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  rbm_state_t        r_state;
  rbm_state_t        w_nextState;
  logic              w_accept;
  logic              r_cs;
  logic              r_rd;
  logic              r_wd;
  logic              r_drive;
  logic              r_reqReady;
  logic              r_rspValid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rspRdata;

  assign w_accept = req_valid && r_reqReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_nextState;
  end

  // INIT holds until its select cycle has actually been presented on the bus.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      INIT:    if (r_cs) w_nextState = IDLE;
      IDLE:    if (w_accept) w_nextState = req_we ? WR : RD_CMD;
      WR:      w_nextState = IDLE;
      RD_CMD:  w_nextState = RD_CAP;
      RD_CAP:  w_nextState = RSP;
      RSP:     if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = INIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs       <= 1'b0;
      r_rd       <= 1'b0;
      r_wd       <= 1'b0;
      r_drive    <= 1'b0;
      r_reqReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rspRdata <= '0;
    end else begin
      r_cs       <= (w_nextState inside {INIT, WR, RD_CMD, RD_CAP});
      r_rd       <= (w_nextState == RD_CMD);
      r_wd       <= (w_nextState == WR);
      r_drive    <= (w_nextState == WR);
      r_reqReady <= (w_nextState == IDLE);
      r_rspValid <= (w_nextState == RSP);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == RD_CAP) r_rspRdata <= ram_data;
    end
  end

  assign ram_data  = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign ram_cs    = r_cs;
  assign ram_rd    = r_rd;
  assign ram_wd    = r_wd;
  assign ram_addr  = r_addr;
  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;

`ifdef RAM_BUS_MASTER_ASSERT_EN
  aRdWdExcl: assert property (@(posedge clk) disable iff (rst) !(ram_rd && ram_wd))
    else $error("ram_rd and ram_wd high together");
  aDriveOnlyWr: assert property (@(posedge clk) disable iff (rst) r_drive |-> (r_state == WR))
    else $error("ram_data driven outside WR");
  aRspHold: assert property (@(posedge clk) disable iff (rst)
      rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_rdata))
    else $error("response not held while stalled");
  aCapKnown: assert property (@(posedge clk) disable iff (rst) (r_state == RD_CAP) |-> !$isunknown(ram_data))
    else $error("ram_data unknown at read capture");
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural 32x8 RAM on a pulled-up shared bus.
// A released bus reads back as 8'hFF, so "nobody driving" is observable as that value.
module tb_ram_bus_master;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 reqValid = 1'b0;
  logic                 reqReady;
  logic                 reqWe = 1'b0;
  ram_bus_pkg::addr_t   reqAddr = '0;
  ram_bus_pkg::data_t   reqWdata = '0;
  logic                 rspValid;
  logic                 rspReady = 1'b1;
  ram_bus_pkg::data_t   rspRdata;
  logic                 ramCs;
  logic                 ramRd;
  logic                 ramWd;
  ram_bus_pkg::addr_t   ramAddr;
  tri1 [7:0]            ramData;

  int compared = 0;
  int mismatched = 0;

  // RAM model: the output enable is deliberately not cleared by reset and starts out driving.
  logic [7:0] ramMem [32];
  logic [7:0] ramDout = 8'hAA;
  logic       ramOe = 1'b1;

  assign ramData = ramOe ? ramDout : 8'hzz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ramMem[i] <= 8'h00;
    end else if (ramCs && ramRd) begin
      ramDout <= ramMem[ramAddr];
      ramOe   <= 1'b1;
    end else if (ramCs && ramWd) begin
      ramMem[ramAddr] <= ramData;
      ramOe           <= 1'b0;
    end else if (ramCs) begin
      ramOe <= 1'b0;
    end
  end

  ram_bus_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_we    (reqWe),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_rdata (rspRdata),
    .ram_cs    (ramCs),
    .ram_rd    (ramRd),
    .ram_wd    (ramWd),
    .ram_addr  (ramAddr),
    .ram_data  (ramData)
  );

  always #5 clk = ~clk;

  // Strobe exclusivity is watched on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      compared++;
      if (ramRd && ramWd) begin
        mismatched++;
        $display("[TB] FAIL rd_wd_excl: got rd=%b wd=%b, want not both high", ramRd, ramWd);
      end
    end
  end

  // Waits for reqReady, presents one request, returns at the negedge of the first bus cycle.
  task automatic applyRequest(input logic we, input logic [4:0] a, input logic [7:0] d);
    int waitCnt = 0;
    while (!reqReady && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!reqReady) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL req_ready_timeout: got req_ready=0 after %0d cycles, want 1", waitCnt);
    end
    reqValid = 1'b1;
    reqWe    = we;
    reqAddr  = a;
    reqWdata = d;
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Counts negedges from the RD_CMD negedge until rspValid appears.
  task automatic waitRsp(output int lat);
    lat = 0;
    while (!rspValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rspValid) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL rsp_timeout: got rsp_valid=0 after %0d cycles, want 1", lat);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if ({ramCs, ramRd, ramWd, reqReady, rspValid} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got cs/rd/wd/rdy/vld=%b, want 00000",
               {ramCs, ramRd, ramWd, reqReady, rspValid});
    end
    compared++;
    if (ramAddr !== 5'd0 || rspRdata !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got addr=%0d rdata=%h, want 0/00", ramAddr, rspRdata);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({ramCs, ramRd, ramWd, reqReady} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL init_cycle: got cs/rd/wd/rdy=%b, want 1000", {ramCs, ramRd, ramWd, reqReady});
    end
    @(negedge clk);
    compared++;
    if ({ramCs, reqReady} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL idle_after_init: got cs/rdy=%b, want 01", {ramCs, reqReady});
    end
    compared++;
    if (ramData !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL bus_released: got %h, want ff (undriven)", ramData);
    end
  endtask

  task automatic test_write_read();
    int lat;
    applyRequest(1'b1, 5'd20, 8'd69);
    compared++;
    if ({ramCs, ramWd, ramRd} !== 3'b110 || ramAddr !== 5'd20 || ramData !== 8'd69) begin
      mismatched++;
      $display("[TB] FAIL wr_cycle: got cs/wd/rd=%b addr=%0d data=%0d, want 110/20/69",
               {ramCs, ramWd, ramRd}, ramAddr, ramData);
    end
    @(negedge clk);
    compared++;
    if (reqReady !== 1'b1 || ramWd !== 1'b0 || ramData !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL wr_done: got rdy=%b wd=%b bus=%h, want 1/0/ff", reqReady, ramWd, ramData);
    end
    applyRequest(1'b0, 5'd20, 8'h00);
    compared++;
    if ({ramCs, ramRd, ramWd, reqReady} !== 4'b1100 || ramAddr !== 5'd20) begin
      mismatched++;
      $display("[TB] FAIL rd_cmd: got cs/rd/wd/rdy=%b addr=%0d, want 1100/20",
               {ramCs, ramRd, ramWd, reqReady}, ramAddr);
    end
    waitRsp(lat);
    compared++;
    if (lat !== 2 || rspRdata !== 8'd69) begin
      mismatched++;
      $display("[TB] FAIL rd20: got latency=%0d rdata=%0d, want 2/69", lat, rspRdata);
    end
    @(negedge clk);
    compared++;
    if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rsp_done: got vld=%b rdy=%b, want 0/1", rspValid, reqReady);
    end
  endtask

  task automatic test_boundary_addr();
    int lat;
    applyRequest(1'b1, 5'd0, 8'hA5);
    @(negedge clk);
    applyRequest(1'b1, 5'd31, 8'h3C);
    compared++;
    if (ramData !== 8'h3C || ramAddr !== 5'd31) begin
      mismatched++;
      $display("[TB] FAIL wr31_bus: got data=%h addr=%0d, want 3c/31", ramData, ramAddr);
    end
    @(negedge clk);
    applyRequest(1'b0, 5'd31, 8'h00);
    waitRsp(lat);
    compared++;
    if (rspRdata !== 8'h3C) begin
      mismatched++;
      $display("[TB] FAIL rd31: got %h, want 3c", rspRdata);
    end
    @(negedge clk);
    applyRequest(1'b0, 5'd0, 8'h00);
    waitRsp(lat);
    compared++;
    if (rspRdata !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL rd0: got %h, want a5", rspRdata);
    end
    @(negedge clk);
  endtask

  task automatic test_rsp_backpressure();
    int lat;
    applyRequest(1'b1, 5'd5, 8'h5A);
    @(negedge clk);
    rspReady = 1'b0;
    applyRequest(1'b0, 5'd5, 8'h00);
    waitRsp(lat);
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (rspValid !== 1'b1 || rspRdata !== 8'h5A || reqReady !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rsp_hold[%0d]: got vld=%b rdata=%h rdy=%b, want 1/5a/0",
                 i, rspValid, rspRdata, reqReady);
      end
      @(negedge clk);
    end
    rspReady = 1'b1;
    @(negedge clk);
    compared++;
    if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rsp_release: got vld=%b rdy=%b, want 0/1", rspValid, reqReady);
    end
  endtask

  task automatic test_reset_midread();
    int lat;
    applyRequest(1'b1, 5'd7, 8'h11);
    @(negedge clk);
    applyRequest(1'b0, 5'd7, 8'h00);
    rst = 1'b1;
    #1;
    compared++;
    if ({rspValid, ramCs, ramRd, reqReady} !== 4'b0000 || ramAddr !== 5'd0 || ramData !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL reset_abort: got vld/cs/rd/rdy=%b addr=%0d bus=%h, want 0000/0/ff",
               {rspValid, ramCs, ramRd, reqReady}, ramAddr, ramData);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (ramCs !== 1'b1 || reqReady !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reinit: got cs=%b rdy=%b, want 1/0", ramCs, reqReady);
    end
    @(negedge clk);
    applyRequest(1'b0, 5'd7, 8'h00);
    waitRsp(lat);
    compared++;
    if (rspRdata !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL rd7_after_reset: got %h, want 00", rspRdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    applyRequest(1'b0, 5'd3, 8'h00);
    waitRsp(lat);
    reqValid = 1'b1;
    reqWe    = 1'b1;
    reqAddr  = 5'd3;
    reqWdata = 8'h55;
    @(negedge clk);
    compared++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0 || ramWd !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle: got rdy=%b vld=%b wd=%b, want 1/0/0", reqReady, rspValid, ramWd);
    end
    @(negedge clk);
    reqValid = 1'b0;
    compared++;
    if (ramWd !== 1'b1 || ramData !== 8'h55 || ramAddr !== 5'd3) begin
      mismatched++;
      $display("[TB] FAIL b2b_wr: got wd=%b data=%h addr=%0d, want 1/55/3", ramWd, ramData, ramAddr);
    end
    @(negedge clk);
    applyRequest(1'b0, 5'd3, 8'h00);
    waitRsp(lat);
    compared++;
    if (rspRdata !== 8'h55) begin
      mismatched++;
      $display("[TB] FAIL rd3: got %h, want 55", rspRdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_boundary_addr();
    test_rsp_backpressure();
    test_reset_midread();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
